reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter D_WIDTH, default 8, SHALL set the width of the light-pattern input.
REQ-002 Parameter C_WIDTH, default 14, SHALL set the width of all millisecond counters and results.
REQ-003 Parameter MAX_MS, default 9999, SHALL set the timeout limit in ms.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 lights  input  D_WIDTH  SHALL carry the start-light pattern from the F1 sequencer.
REQ-007 tick_ms  input  1  SHALL be a one-cycle 1 kHz enable pulse from the clktick divider.
REQ-008 button  input  1  SHALL be the raw, asynchronous driver push-button; high = pressed.
REQ-009 clear  input  1  SHALL be a synchronous request to return to IDLE.
REQ-010 react_ms  output  C_WIDTH  SHALL hold the last measured reaction time in ms.
REQ-011 valid  output  1  SHALL pulse high for one cycle when react_ms updates.
REQ-012 foul  output  1  SHALL be high while in FOUL (jump start).
REQ-013 timeout  output  1  SHALL be high while in TIMEOUT.
REQ-014 busy  output  1  SHALL be high while in TIMING.
REQ-015 state  output  3  SHALL expose the FSM encoding.

Function
REQ-016 button SHALL pass a 2-flop synchroniser, then a rising-edge detector; "press" means one cycle of the detected edge (total latency 3 cycles from the pin).
REQ-017 FSM states and encoding SHALL be IDLE=0, ARMED=1, TIMING=2, DONE=3, FOUL=4, TIMEOUT=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-018 IDLE: lights == all-ones -> ARMED; presses ignored.
REQ-019 ARMED: press -> FOUL; lights == 0 -> TIMING with counter loaded to 0; both in the same cycle -> FOUL.
REQ-020 TIMING: counter SHALL increment by 1 on each tick_ms.
REQ-021 TIMING: a press SHALL make react_ms the pre-increment counter value, pulse valid, and go to DONE; a press together with tick_ms SHALL capture the pre-increment value.
REQ-022 TIMING: counter == MAX_MS with no press -> TIMEOUT; react_ms SHALL be unchanged and valid SHALL NOT pulse.
REQ-023 DONE, FOUL and TIMEOUT SHALL hold until clear (-> IDLE) or lights == all-ones (-> ARMED); clear SHALL win if both occur together.
REQ-024 clear SHALL take effect from every state, including mid-TIMING; react_ms SHALL NOT be modified by clear.
REQ-025 The counter SHALL never wrap; it SHALL saturate at MAX_MS.
REQ-026 foul, timeout and busy SHALL be decoded from the registered state (Moore, no combinational path from inputs).

Reset
REQ-027 With rst low, the block SHALL immediately set state=IDLE, react_ms=0, counter=0, valid=0, synchroniser flops=0 and edge-detect history=0.
REQ-028 After rst rises, a button already held high SHALL produce no press until released and pressed again.

Configuration
REQ-029 Macro REACTION_BEST_TIME_EN defined: add output best_ms [C_WIDTH-1:0], reset to all-ones, updated to react_ms when valid pulses with a value < best_ms, and cleared to all-ones only by rst.
REQ-030 Macro REACTION_BEST_TIME_EN undefined: the best_ms port and its logic SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-031 lights 0->FF->00, then 250 tick_ms pulses, then a button rise -> valid for 1 cycle, react_ms=250, state=DONE.
REQ-032 lights=FF, button rise before lights=00 -> state=FOUL, foul=1, react_ms unchanged, no valid.
REQ-033 lights FF->00, no press, 9999 ticks -> state=TIMEOUT, timeout=1, counter held at 9999, no valid.
REQ-034 In ARMED, press and lights=00 in the same cycle -> FOUL; in TIMING, press and tick_ms together at count 42 -> react_ms=42.
REQ-035 rst pulled low mid-TIMING at count 100 -> IDLE with all outputs 0 asynchronously; button held across reset release -> no press.
REQ-036 With REACTION_BEST_TIME_EN, runs of 300 then 180 then 220 ms -> best_ms=300, 180, 180; clear leaves best_ms at 180.

Source files
------------

// File: rtl/reaction_timer.sv
// F1-style reaction timer: waits for the start lights, times the driver's press in ms.
// Optional best-time tracking is built when REACTION_BEST_TIME_EN is defined.
module reaction_timer #(
  parameter int D_WIDTH = 8,
  parameter int C_WIDTH = 14,
  parameter int MAX_MS  = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] lights,
  input  logic               tick_ms,
  input  logic               button,
  input  logic               clear,
  output logic [C_WIDTH-1:0] react_ms,
  output logic               valid,
  output logic               foul,
  output logic               timeout,
  output logic               busy,
  output logic [2:0]         state
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [C_WIDTH-1:0] best_ms
`endif
);

  // state   | meaning
  // IDLE    | waiting for all start lights on
  // ARMED   | lights on, waiting for lights out; a press here is a jump start
  // TIMING  | lights out, counting ms until the press
  // DONE    | reaction captured in react_ms
  // FOUL    | pressed before lights out
  // TIMEOUT | no press within MAX_MS
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    TIMING  = 3'd2,
    DONE    = 3'd3,
    FOUL    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  localparam logic [C_WIDTH-1:0] MAX_C = C_WIDTH'(MAX_MS);

  state_t             state_q, state_d;
  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_WIDTH-1:0] react_q, react_d;
  logic               valid_q, valid_d;

  logic               btn_meta_q, btn_sync_q, btn_hist_q;
  logic [1:0]         btn_fill_q, btn_fill_d;
  logic               btn_ready_q, btn_ready_d;
  logic               press;
  logic               lights_full, lights_zero;

  // A press needs a low level seen after the synchroniser has filled with real
  // samples, so a button held through reset release never counts as a press.
  always_comb begin
    btn_fill_d  = {btn_fill_q[0], 1'b1};
    btn_ready_d = btn_ready_q | (btn_fill_q[1] & ~btn_sync_q);
    press       = btn_sync_q & ~btn_hist_q & btn_ready_q;
    lights_full = &lights;
    lights_zero = (lights == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    react_d = react_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clear && lights_full) state_d = ARMED;
      end
      ARMED: begin
        if (clear) state_d = IDLE;
        else if (press) state_d = FOUL;
        else if (lights_zero) begin
          state_d = TIMING;
          cnt_d   = '0;
        end
      end
      TIMING: begin
        if (clear) state_d = IDLE;
        else if (press) begin
          react_d = cnt_q;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q == MAX_C) state_d = TIMEOUT;
        else if (tick_ms) cnt_d = cnt_q + C_WIDTH'(1);
      end
      DONE, FOUL, TIMEOUT: begin
        if (clear) state_d = IDLE;
        else if (lights_full) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      react_q     <= '0;
      valid_q     <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_hist_q  <= 1'b0;
      btn_fill_q  <= 2'b00;
      btn_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      react_q     <= react_d;
      valid_q     <= valid_d;
      btn_meta_q  <= button;
      btn_sync_q  <= btn_meta_q;
      btn_hist_q  <= btn_sync_q;
      btn_fill_q  <= btn_fill_d;
      btn_ready_q <= btn_ready_d;
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [C_WIDTH-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (valid_q && (react_q < best_q)) best_d = react_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) best_q <= '1;
    else      best_q <= best_d;
  end

  assign best_ms = best_q;
`endif

  assign react_ms = react_q;
  assign valid    = valid_q;
  assign state    = state_q;
  assign foul     = (state_q == FOUL);
  assign timeout  = (state_q == TIMEOUT);
  assign busy     = (state_q == TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: expected reaction times are queued at
// each press and compared whenever valid pulses.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  lights = 8'h00;
  logic        tick = 1'b0;
  logic        button = 1'b0;
  logic        clear = 1'b0;
  logic [13:0] react_ms;
  logic        valid, foul, timeout, busy;
  logic [2:0]  state;
`ifdef REACTION_BEST_TIME_EN
  logic [13:0] best_ms;
`endif

  int total = 0;
  int bad = 0;
  logic [13:0] sb[$];

  reaction_timer dut (
    .clk      (clk),
    .rst      (rst_n),
    .lights   (lights),
    .tick_ms  (tick),
    .button   (button),
    .clear    (clear),
    .react_ms (react_ms),
    .valid    (valid),
    .foul     (foul),
    .timeout  (timeout),
    .busy     (busy),
    .state    (state)
`ifdef REACTION_BEST_TIME_EN
    ,
    .best_ms  (best_ms)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  // Release, then a clean rise; the FSM acts on it at the third edge.
  task automatic press_pin();
    button = 1'b0;
    step(4);
    button = 1'b1;
    step(3);
    button = 1'b0;
  endtask

  task automatic arm_and_start();
    lights = 8'hFF;
    step(2);
    lights = 8'h00;
    step(2);
  endtask

  task automatic timed_run(input int n);
    arm_and_start();
    tick_n(n);
    sb.push_back(14'(n));
    press_pin();
    check_val("run_state", state, 3);
    check_val("run_valid", valid, 1);
    check_val("run_react", react_ms, n);
    step(1);
    check_val("run_valid_low", valid, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) check_val("valid_unexpected", valid, 0);
      else check_val("react_sb", react_ms, sb.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    #2;
    check_val("rst_state", state, 0);
    check_val("rst_react", react_ms, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_flags", {foul, timeout, busy}, 0);
`ifdef REACTION_BEST_TIME_EN
    check_val("rst_best", best_ms, 14'h3FFF);
`endif
    step(2);
    rst_n = 1'b1;
    step(4);

    // presses in IDLE are ignored
    press_pin();
    check_val("idle_press", state, 0);

    // nominal 250 ms reaction
    lights = 8'hFF;
    step(2);
    check_val("armed", state, 1);
    lights = 8'h00;
    step(2);
    check_val("timing", state, 2);
    check_val("timing_busy", busy, 1);
    tick_n(250);
    sb.push_back(14'd250);
    press_pin();
    check_val("done_state", state, 3);
    check_val("done_valid", valid, 1);
    check_val("done_react", react_ms, 250);
    step(1);
    check_val("done_valid_low", valid, 0);
    check_val("done_busy", busy, 0);

    // jump start from DONE via lights all-on
    lights = 8'hFF;
    step(2);
    check_val("rearm", state, 1);
    press_pin();
    check_val("foul_state", state, 4);
    check_val("foul_flag", foul, 1);
    check_val("foul_react", react_ms, 250);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clear_foul", state, 0);

    // press and lights-out together in ARMED
    lights = 8'hFF;
    step(2);
    button = 1'b0;
    step(4);
    button = 1'b1;
    step(2);
    lights = 8'h00;
    step(1);
    button = 1'b0;
    check_val("tie_foul", state, 4);

    // press coinciding with a tick at count 42
    arm_and_start();
    check_val("tie_timing", state, 2);
    tick_n(42);
    sb.push_back(14'd42);
    button = 1'b0;
    step(4);
    button = 1'b1;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    button = 1'b0;
    check_val("tick_press_state", state, 3);
    check_val("tick_press_react", react_ms, 42);

    // clear mid-TIMING keeps react_ms
    arm_and_start();
    tick_n(5);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clear_timing", state, 0);
    check_val("clear_keeps_react", react_ms, 42);

    // asynchronous reset at count 100 with button held across release
    arm_and_start();
    tick_n(100);
    check_val("pre_rst_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    button = 1'b1;
    #1;
    check_val("async_state", state, 0);
    check_val("async_react", react_ms, 0);
    check_val("async_busy", busy, 0);
    step(2);
    lights = 8'hFF;
    rst_n = 1'b1;
    step(8);
    check_val("held_no_press", state, 1);
    press_pin();
    check_val("press_after_release", state, 4);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // timeout at MAX_MS
    arm_and_start();
    tick_n(9998);
    check_val("pre_timeout", state, 2);
    tick_n(1);
    check_val("timeout_state", state, 5);
    check_val("timeout_flag", timeout, 1);
    check_val("timeout_react", react_ms, 0);
    press_pin();
    check_val("timeout_hold", state, 5);

    // clear beats lights all-on
    clear = 1'b1;
    lights = 8'hFF;
    step(1);
    clear = 1'b0;
    check_val("clear_priority", state, 0);
    step(1);
    check_val("after_priority", state, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    timed_run(300);
`ifdef REACTION_BEST_TIME_EN
    check_val("best_300", best_ms, 300);
`endif
    timed_run(180);
`ifdef REACTION_BEST_TIME_EN
    check_val("best_180", best_ms, 180);
`endif
    timed_run(220);
`ifdef REACTION_BEST_TIME_EN
    check_val("best_220", best_ms, 180);
`endif
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("final_clear", state, 0);
`ifdef REACTION_BEST_TIME_EN
    check_val("best_after_clear", best_ms, 180);
`endif

    step(2);
    check_val("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
